// File: rtl/hls_run_ctrl.sv
// Job sequencer for an ap_ctrl_hs kernel: issues cfg_num_runs invocations, checks the
// output-stream beat count and last framing of every run, and guards each run with a watchdog.
module hls_run_ctrl #(
  parameter int RUN_W  = 16,
  parameter int BEAT_W = 32,
  parameter int TMO_W  = 20
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              cfg_start,
  input  logic [RUN_W-1:0]  cfg_num_runs,
  input  logic [BEAT_W-1:0] cfg_beats,
  input  logic [TMO_W-1:0]  cfg_timeout,
  input  logic              cfg_abort,
  output logic              k_ap_start,
  input  logic              k_ap_ready,
  input  logic              k_ap_done,
  input  logic              k_ap_idle,
  input  logic              mon_vld,
  input  logic              mon_ack,
  input  logic              mon_last,
  output logic              busy,
  output logic              done_pulse,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [RUN_W-1:0]  runs_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_NEXT,
    S_FINISH,
    S_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_BEAT = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_CFG  = 2'd3;

  state_t            state, state_n;
  logic [RUN_W-1:0]  num_runs_q;
  logic [BEAT_W-1:0] beats_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [BEAT_W-1:0] beat_cnt, beat_cnt_n, beats_after;
  logic [TMO_W-1:0]  wdog, wdog_n;
  logic              done_hold, done_hold_n;
  logic              k_ap_start_n;
  logic [1:0]        err_code_n;
  logic [RUN_W-1:0]  runs_done_n, runs_inc;
  logic              cfg_load;
  logic              beat, beat_err, all_beats, done_eff, wdog_hit, in_run_phase;

  // Watchdog never wraps, so a disabled (zero) limit simply parks it at all-ones.
  function automatic logic [TMO_W-1:0] wdog_sat_inc(input logic [TMO_W-1:0] v);
    return (&v) ? v : v + TMO_W'(1);
  endfunction

  // A beat is malformed if it overruns the run, or if last disagrees with "this is the final beat".
  function automatic logic beat_malformed(input logic [BEAT_W-1:0] idx,
                                          input logic [BEAT_W-1:0] total,
                                          input logic              last);
    if (idx >= total) return 1'b1;
    return (idx == total - BEAT_W'(1)) != last;
  endfunction

  assign beat         = mon_vld & mon_ack;
  assign beat_err     = beat & beat_malformed(beat_cnt, beats_q, mon_last);
  assign beats_after  = beat ? beat_cnt + BEAT_W'(1) : beat_cnt;
  assign all_beats    = (beats_after == beats_q);
  assign done_eff     = k_ap_done | done_hold;
  assign wdog_hit     = (tmo_q != '0) && !beat && (wdog_sat_inc(wdog) == tmo_q);
  assign runs_inc     = runs_done + RUN_W'(1);
  assign in_run_phase = (state == S_START) || (state == S_RUN);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= S_IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n      = state;
    beat_cnt_n   = beat_cnt;
    wdog_n       = wdog;
    done_hold_n  = done_hold;
    err_code_n   = err_code;
    runs_done_n  = runs_done;
    cfg_load     = 1'b0;
    k_ap_start_n = 1'b0;

    case (state)
      S_IDLE, S_ERR: begin
        if (cfg_start) begin
          if (cfg_num_runs == '0 || cfg_beats == '0) begin
            state_n    = S_ERR;
            err_code_n = ERR_CFG;
          end else begin
            state_n     = S_START;
            cfg_load    = 1'b1;
            err_code_n  = ERR_NONE;
            runs_done_n = '0;
          end
        end
      end
      S_START: begin
        if (cfg_abort) begin
          state_n = S_IDLE;
        end else if (beat_err) begin
          state_n    = S_ERR;
          err_code_n = ERR_BEAT;
        end else if (wdog_hit) begin
          state_n    = S_ERR;
          err_code_n = ERR_TMO;
        end else if (k_ap_start && k_ap_ready) begin
          // A done coincident with ready belongs to this run; keep it for RUN to judge.
          state_n     = S_RUN;
          done_hold_n = k_ap_done;
        end
      end
      S_RUN: begin
        if (cfg_abort) begin
          state_n = S_IDLE;
        end else if (beat_err) begin
          state_n    = S_ERR;
          err_code_n = ERR_BEAT;
        end else if (done_eff) begin
          state_n = all_beats ? S_NEXT : S_ERR;
          if (!all_beats) err_code_n = ERR_BEAT;
        end else if (wdog_hit) begin
          state_n    = S_ERR;
          err_code_n = ERR_TMO;
        end
      end
      S_NEXT: begin
        if (cfg_abort) begin
          state_n = S_IDLE;
        end else begin
          runs_done_n = runs_inc;
          state_n     = (runs_inc == num_runs_q) ? S_FINISH : S_START;
        end
      end
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase

    // Per-run counters restart whenever a run phase is (re)entered.
    if ((state_n == S_START || state_n == S_RUN) && state_n != state) begin
      wdog_n = '0;
    end else if (in_run_phase) begin
      wdog_n = beat ? '0 : wdog_sat_inc(wdog);
    end

    if (state_n == S_START && state != S_START) begin
      beat_cnt_n  = '0;
      done_hold_n = 1'b0;
    end else if (in_run_phase && beat) begin
      beat_cnt_n = beat_cnt + BEAT_W'(1);
    end

    // ap_start rises only once the kernel reports idle, then holds until ready.
    if (state == S_START && state_n == S_START) begin
      k_ap_start_n = k_ap_start | k_ap_idle;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      num_runs_q <= '0;
      beats_q    <= '0;
      tmo_q      <= '0;
      beat_cnt   <= '0;
      wdog       <= '0;
      done_hold  <= 1'b0;
      k_ap_start <= 1'b0;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
      error      <= 1'b0;
      err_code   <= ERR_NONE;
      runs_done  <= '0;
    end else begin
      if (cfg_load) begin
        num_runs_q <= cfg_num_runs;
        beats_q    <= cfg_beats;
        tmo_q      <= cfg_timeout;
      end
      beat_cnt   <= beat_cnt_n;
      wdog       <= wdog_n;
      done_hold  <= done_hold_n;
      k_ap_start <= k_ap_start_n;
      busy       <= (state_n != S_IDLE) && (state_n != S_ERR);
      done_pulse <= (state_n == S_FINISH);
      error      <= (state_n == S_ERR);
      err_code   <= err_code_n;
      runs_done  <= runs_done_n;
    end
  end

endmodule

// File: doc/hls_run_ctrl.md
HLS_RUN_CTRL -- requirements
Module: hls_run_ctrl

Interface
REQ-001 Parameter RUN_W, default 16, SHALL set the width of the run counter and of cfg_num_runs.
REQ-002 Parameter BEAT_W, default 32, SHALL set the width of the beat counter and of cfg_beats.
REQ-003 Parameter TMO_W, default 20, SHALL set the width of the watchdog counter and of cfg_timeout.
REQ-004 ap_clk  in  1  SHALL be the single clock.
REQ-005 ap_rst_n  in  1  SHALL be the reset: asynchronous assert, active-low.
REQ-006 cfg_start  in  1  SHALL be a one-cycle job request, sampled only in IDLE or ERR.
REQ-007 cfg_num_runs  in  RUN_W  SHALL give the kernel invocations per job.
REQ-008 cfg_beats  in  BEAT_W  SHALL give the output beats expected per run.
REQ-009 cfg_timeout  in  TMO_W  SHALL give the watchdog limit in cycles; 0 disables the watchdog.
REQ-010 cfg_abort  in  1  SHALL be a synchronous abort request.
REQ-011 k_ap_start  out  1  SHALL drive the kernel ap_start.
REQ-012 k_ap_ready, k_ap_done, k_ap_idle  in  1 each  SHALL be the kernel ap_ctrl_hs status inputs.
REQ-013 mon_vld, mon_ack, mon_last  in  1 each  SHALL be passive taps of the kernel output stream ap_vld, ap_ack and last value.
REQ-014 busy  out  1  SHALL be high in every state except IDLE and ERR.
REQ-015 done_pulse  out  1  SHALL pulse for one cycle when a job completes.
REQ-016 error  out  1  SHALL be high while in state ERR.
REQ-017 err_code  out  2  SHALL hold the error cause: 0 none, 1 beat/last mismatch, 2 timeout, 3 bad config.
REQ-018 runs_done  out  RUN_W  SHALL count the runs completed in the current job.

Function
REQ-019 The states SHALL be IDLE, START, RUN, NEXT, FINISH and ERR, and all outputs SHALL be registered.
REQ-020 In IDLE or ERR, a cfg_start with cfg_num_runs≠0 and cfg_beats≠0 SHALL latch all cfg_* inputs, clear runs_done and err_code, and go to START.
REQ-021 In IDLE or ERR, a cfg_start with cfg_num_runs=0 or cfg_beats=0 SHALL go to ERR with err_code=3.
REQ-022 k_ap_start SHALL be 1 from the cycle after START is entered.
REQ-023 k_ap_start SHALL be held at 1 until k_ap_ready is sampled 1, then go to 0 in the next cycle as the FSM enters RUN.
REQ-024 In START, if k_ap_ready and k_ap_done are both 1 in the same cycle, the done SHALL be retained and counted for that run.
REQ-025 An output beat SHALL be counted when mon_vld & mon_ack is 1; the beat counter SHALL clear on entry to START.
REQ-026 A beat with mon_last=1 whose index is below cfg_beats-1 SHALL go to ERR with err_code=1.
REQ-027 Beat index cfg_beats-1 with mon_last=0 SHALL go to ERR with err_code=1.
REQ-028 Beats after cfg_beats within the same run SHALL go to ERR with err_code=1.
REQ-029 In RUN, k_ap_done sampled before all cfg_beats beats are counted SHALL go to ERR with err_code=1.
REQ-030 In RUN, k_ap_done in the same cycle as the final beat, or any cycle after it, SHALL go to NEXT.
REQ-031 NEXT SHALL last one cycle and increment runs_done.
REQ-032 From NEXT, the FSM SHALL go to FINISH if runs_done+1 equals cfg_num_runs, otherwise to START.
REQ-033 FINISH SHALL assert done_pulse for one cycle and then go to IDLE; runs_done SHALL hold its final value.
REQ-034 The watchdog SHALL clear on entry to START or RUN and on each counted beat, and SHALL increment otherwise while in START or RUN.
REQ-035 When cfg_timeout≠0 and the watchdog reaches cfg_timeout, the FSM SHALL go to ERR with err_code=2.
REQ-036 If an error condition and cfg_abort occur in the same cycle, cfg_abort SHALL take priority.
REQ-037 cfg_abort in any busy state SHALL go to IDLE, set k_ap_start=0, produce no done_pulse, leave err_code=0 and hold runs_done.
REQ-038 Entering ERR SHALL set k_ap_start=0.
REQ-039 ERR SHALL be left only through cfg_start (REQ-020, REQ-021); cfg_abort in ERR SHALL be ignored.
REQ-040 cfg_start while busy SHALL be ignored.
REQ-041 k_ap_idle SHALL be used only to gate START entry: the FSM SHALL wait in START with k_ap_start=0 until k_ap_idle=1.

Reset
REQ-042 While ap_rst_n=0, the FSM SHALL be in IDLE and all counters and latched cfg_* values SHALL be 0.
REQ-043 While ap_rst_n=0, the outputs SHALL be k_ap_start=0, busy=0, done_pulse=0, error=0, err_code=0 and runs_done=0.
REQ-044 Reset asserted mid-job SHALL take effect immediately, with no done_pulse.

Verification
REQ-045 Job of 2 runs × 4 beats, last on beat 3, done 2 cycles after beat 3 -> two k_ap_start handshakes, runs_done=2, one done_pulse, err_code=0.
REQ-046 Job of 1 run × 4 beats with mon_last on beat 1 -> ERR, err_code=1, k_ap_start=0.
REQ-047 cfg_timeout=10 with no output beats after ready -> ERR with err_code=2 exactly 10 cycles after RUN entry.
REQ-048 cfg_num_runs=0 -> ERR, err_code=3, k_ap_start never asserted; a following valid cfg_start clears the error and runs normally.
REQ-049 cfg_abort during run 2 of 3 -> IDLE next cycle, runs_done=1, no done_pulse.
REQ-050 ap_rst_n pulsed low while k_ap_start=1 -> all outputs 0 asynchronously; IDLE after reset release.
